weight_bank_seq_ctrl: RTL and testbench

- Sequences the per-neuron weight BRAM banks: NUM_BANKS banks × DEPTH words, 28×28 = 784 weights per neuron.
- Sweeps all banks in bank-major order and streams the weights to the MAC datapath over a valid/ready handshake.
- Shares the BRAM ports with the weight loader, which writes single words while the controller is idle.
- Sits between the weight BRAMs (read on negedge CLK) and the neuron MAC.

---
 rtl/ann_weight_pkg.sv | 34 +++
 rtl/weight_out_fifo2.sv | 41 ++++
 rtl/weight_bank_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_weight_bank_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_weight_pkg.sv
// Shared constants, FSM state type and bank-decode helper for the weight bank sequencer.
package ann_weight_pkg;

    localparam int NUM_BANKS     = 28;
    localparam int DEPTH         = 28;
    localparam int ADDR_W        = 5;
    localparam int BANK_W        = 5;
    localparam int DATA_W        = 16;
    localparam int TOTAL_WEIGHTS = NUM_BANKS * DEPTH;

    localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] BANK_LIMIT = BANK_W'(NUM_BANKS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Out-of-range bank indices decode to an all-zero enable.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
        logic [NUM_BANKS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank == BANK_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/weight_out_fifo2.sv
// Two-entry FIFO for {last, data} words; push and pop may coincide even when full.
module weight_out_fifo2 #(
    parameter int W = 17
) (
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/weight_bank_seq_ctrl.sv
// Sweeps the weight BRAM banks bank-major and streams words over valid/ready;
// loader writes share the BRAM ports while idle. Optional STALL_CNT via WEIGHT_SEQ_STALL_CNT_EN.
module weight_bank_seq_ctrl
    import ann_weight_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [NUM_BANKS-1:0]        BRAM_EN,
    output logic                        BRAM_WE,
    output logic [ADDR_W-1:0]           BRAM_ADDR,
    output logic [DATA_W-1:0]           BRAM_DI,
    input  logic [NUM_BANKS*DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0]           W_DATA,
    output logic                        W_VALID,
    input  logic                        W_READY,
    output logic                        W_LAST,
    input  logic                        LD_REQ,
    input  logic [BANK_W-1:0]           LD_BANK,
    input  logic [ADDR_W-1:0]           LD_ADDR,
    input  logic [DATA_W-1:0]           LD_DATA,
    output logic                        LD_ACK
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                 STALL_CNT
`endif
);

    seq_state_t             r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [BANK_W-1:0]      r_bank;
    logic [ADDR_W-1:0]      r_addr;
    logic [NUM_BANKS-1:0]   r_rd_en;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic                   r_rd_valid;
    logic [BANK_W-1:0]      r_rd_bank;
    logic                   r_rd_last;

    logic [DATA_W-1:0]      w_do_bank [NUM_BANKS];
    logic [DATA_W-1:0]      w_push_word;
    logic [DATA_W:0]        w_fifo_data;
    logic                   w_fifo_valid;
    logic [1:0]             w_fifo_count;
    logic                   w_pop;
    logic [2:0]             w_occ;
    logic                   w_room;
    logic                   w_issue;
    logic                   w_at_last;
    logic                   w_ld_act;
    logic                   w_ld_ok;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_do_unpack
            assign w_do_bank[gi] = BRAM_DO[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        w_push_word = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_rd_bank == BANK_W'(i)) begin
                w_push_word = w_do_bank[i];
            end
        end
    end

    // Occupancy after the next edge must stay within the two FIFO slots.
    assign w_pop     = w_fifo_valid && W_READY;
    assign w_occ     = {1'b0, w_fifo_count} + {2'b00, r_rd_valid};
    assign w_room    = (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_at_last = (r_bank == LAST_BANK) && (r_addr == LAST_ADDR);
    assign w_issue   = w_room && ((r_state == ST_SWEEP) || ((r_state == ST_IDLE) && START));

    // Loader path is combinational and only owns the ports while idle.
    assign w_ld_act = (r_state == ST_IDLE) && LD_REQ && !RST;
    assign w_ld_ok  = w_ld_act && (LD_BANK < BANK_LIMIT) && (LD_ADDR < ADDR_LIMIT);

    assign BRAM_EN   = w_ld_ok ? bank_onehot(LD_BANK) : r_rd_en;
    assign BRAM_WE   = w_ld_ok;
    assign BRAM_ADDR = w_ld_ok ? LD_ADDR : r_rd_addr;
    assign BRAM_DI   = w_ld_ok ? LD_DATA : '0;
    assign LD_ACK    = w_ld_act;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bank     <= '0;
            r_addr     <= '0;
            r_rd_en    <= '0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_en    <= '0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;

            if (w_issue) begin
                r_rd_en    <= bank_onehot(r_bank);
                r_rd_addr  <= r_addr;
                r_rd_valid <= 1'b1;
                r_rd_bank  <= r_bank;
                r_rd_last  <= w_at_last;
                if (w_at_last) begin
                    r_bank <= '0;
                    r_addr <= '0;
                end else if (r_addr == LAST_ADDR) begin
                    r_bank <= r_bank + 1'b1;
                    r_addr <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_state <= w_at_last ? ST_DRAIN : ST_SWEEP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (w_issue && w_at_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_fifo_data[DATA_W]) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    weight_out_fifo2 #(
        .W (DATA_W + 1)
    ) u_out_fifo (
        .i_clk   (CLK),
        .i_srst  (RST),
        .i_push  (r_rd_valid),
        .i_data  ({r_rd_last, w_push_word}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign W_DATA  = w_fifo_data[DATA_W-1:0];
    assign W_LAST  = w_fifo_data[DATA_W] && w_fifo_valid;
    assign W_VALID = w_fifo_valid;
    assign BUSY    = r_busy;
    assign DONE    = r_done;

`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_IDLE) && START) begin
            r_stall_cnt <= '0;
        end else if (r_busy && w_fifo_valid && !W_READY && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_weight_bank_seq_ctrl.sv
// Directed bench for weight_bank_seq_ctrl: loader vector table, preload, and multi-cycle sweep sequences.
module tb_weight_bank_seq_ctrl;
    import ann_weight_pkg::*;

    logic                        clk = 1'b0;
    logic                        RST;
    logic                        START;
    logic                        BUSY;
    logic                        DONE;
    logic [NUM_BANKS-1:0]        BRAM_EN;
    logic                        BRAM_WE;
    logic [ADDR_W-1:0]           BRAM_ADDR;
    logic [DATA_W-1:0]           BRAM_DI;
    logic [NUM_BANKS*DATA_W-1:0] BRAM_DO;
    logic [DATA_W-1:0]           W_DATA;
    logic                        W_VALID;
    logic                        W_READY;
    logic                        W_LAST;
    logic                        LD_REQ;
    logic [BANK_W-1:0]           LD_BANK;
    logic [ADDR_W-1:0]           LD_ADDR;
    logic [DATA_W-1:0]           LD_DATA;
    logic                        LD_ACK;
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0]                 STALL_CNT;
`endif

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] bmem    [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0] bdo     [NUM_BANKS];
    logic [DATA_W-1:0] exp_mem [NUM_BANKS][DEPTH];

    always #5 clk = ~clk;

    weight_bank_seq_ctrl dut (
        .CLK       (clk),
        .RST       (RST),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DI   (BRAM_DI),
        .BRAM_DO   (BRAM_DO),
        .W_DATA    (W_DATA),
        .W_VALID   (W_VALID),
        .W_READY   (W_READY),
        .W_LAST    (W_LAST),
        .LD_REQ    (LD_REQ),
        .LD_BANK   (LD_BANK),
        .LD_ADDR   (LD_ADDR),
        .LD_DATA   (LD_DATA),
        .LD_ACK    (LD_ACK)
`ifdef WEIGHT_SEQ_STALL_CNT_EN
        ,
        .STALL_CNT (STALL_CNT)
`endif
    );

    // Behavioural BRAM banks: write and read both on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (BRAM_EN[k] && (int'(BRAM_ADDR) < DEPTH)) begin
                if (BRAM_WE) bmem[k][BRAM_ADDR] <= BRAM_DI;
                else         bdo[k] <= bmem[k][BRAM_ADDR];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_do
            assign BRAM_DO[gi*DATA_W +: DATA_W] = bdo[gi];
        end
    endgenerate

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            2:       return !((c >= 5) && (c < 15));
            default: return 1'b1;
        endcase
    endfunction

    typedef struct {
        logic                 req;
        logic [BANK_W-1:0]    bank;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        logic                 ack;
        logic [NUM_BANKS-1:0] en;
        logic                 chk_wad;
        logic                 we;
        logic [ADDR_W-1:0]    eaddr;
        logic [DATA_W-1:0]    edi;
    } vec_t;

    vec_t vecs [7];

    // mode: ready pattern; ld_mid: loader request held from cycle 100;
    // st_ld: loader write in the START cycle; abort_at: reset after that many words (-1 = none)
    task automatic do_sweep(input string tag, input int mode, input bit ld_mid,
                            input bit st_ld, input int abort_at);
        int cyc = 0, hs = 0, first_v = -1, last_hs = -1, done_cnt = 0, done_cyc = -1;
        int issued = 0, max_out = 0, ack_early = 0;
        bit finished = 0, aborted = 0, stalled_prev = 0;
        logic [DATA_W-1:0] prev_d = '0;
        logic prev_l = 1'b0;

        @(posedge clk); #1;
        START   = 1'b1;
        W_READY = rdy(mode, 0);
        if (st_ld) begin
            LD_REQ = 1'b1; LD_BANK = 5'd0; LD_ADDR = 5'd0; LD_DATA = 16'h1234;
        end
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, "_busy_c0"}, BUSY, 0);
                if (st_ld) begin
                    check({tag, "_st_ack"}, LD_ACK, 1);
                    check({tag, "_st_en"}, BRAM_EN, 32'h1);
                    exp_mem[0][0] = 16'h1234;
                end
            end
            if (cyc == 1) begin
                check({tag, "_busy_c1"}, BUSY, 1);
`ifdef WEIGHT_SEQ_STALL_CNT_EN
                check({tag, "_stall_clr"}, STALL_CNT, 0);
`endif
            end
            if (LD_REQ && LD_ACK && BUSY) ack_early++;
            if ((BRAM_EN != '0) && !BRAM_WE) issued++;
            if (W_VALID && first_v < 0) first_v = cyc;
            if (stalled_prev) begin
                check({tag, "_hold_valid"}, W_VALID, 1);
                check({tag, "_hold_data"}, W_DATA, prev_d);
                check({tag, "_hold_last"}, W_LAST, prev_l);
            end
            if (W_VALID && W_READY) begin
                if (hs < TOTAL_WEIGHTS) begin
                    check({tag, "_word"}, W_DATA, exp_mem[hs / DEPTH][hs % DEPTH]);
                    check({tag, "_last_tag"}, W_LAST, (hs == TOTAL_WEIGHTS - 1));
                end else begin
                    check({tag, "_word_overrun"}, hs, TOTAL_WEIGHTS - 1);
                end
                if (hs == TOTAL_WEIGHTS - 1) last_hs = cyc;
                hs++;
            end
            if ((issued - hs) > max_out) max_out = issued - hs;
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
                check({tag, "_busy_at_done"}, BUSY, 0);
                if (ld_mid) begin
                    check({tag, "_ld_ack_at_done"}, LD_ACK, 1);
                    exp_mem[3][5] = LD_DATA;
                end
`ifdef WEIGHT_SEQ_STALL_CNT_EN
                if (mode == 2) check({tag, "_stall_cnt"}, STALL_CNT, 10);
`endif
                finished = 1;
            end
            stalled_prev = W_VALID && !W_READY;
            prev_d = W_DATA;
            prev_l = W_LAST;
            if (!finished && abort_at >= 0 && hs >= abort_at) begin
                @(posedge clk); #1;
                RST = 1'b1;
                @(posedge clk); #1;
                RST = 1'b0;
                @(negedge clk);
                check({tag, "_rst_busy"}, BUSY, 0);
                check({tag, "_rst_valid"}, W_VALID, 0);
                check({tag, "_rst_done"}, DONE, 0);
                check({tag, "_rst_en"}, BRAM_EN, 0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (DONE) done_cnt++;
                end
                aborted  = 1;
                finished = 1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                START = 1'b0;
                cyc++;
                W_READY = rdy(mode, cyc);
                if (st_ld && cyc == 1) LD_REQ = 1'b0;
                if (ld_mid && cyc == 100) begin
                    LD_REQ = 1'b1; LD_BANK = 5'd3; LD_ADDR = 5'd5; LD_DATA = 16'h7A5A;
                end
            end
        end
        check({tag, "_finished"}, finished, 1);
        if (aborted) begin
            check({tag, "_abort_no_done"}, done_cnt, 0);
        end else begin
            check({tag, "_words"}, hs, TOTAL_WEIGHTS);
            check({tag, "_done_cnt"}, done_cnt, 1);
            check({tag, "_done_cyc"}, done_cyc, last_hs + 1);
            check({tag, "_first_valid"}, first_v, 2);
            check({tag, "_max_out_le2"}, (max_out <= 2), 1);
            if (mode == 0) check({tag, "_last_cyc"}, last_hs, TOTAL_WEIGHTS + 1);
            if (ld_mid) check({tag, "_ld_ack_busy"}, ack_early, 0);
            @(posedge clk); #1;
            START = 1'b0;
            LD_REQ = 1'b0;
            W_READY = 1'b1;
            @(negedge clk);
            check({tag, "_done_pulse"}, DONE, 0);
            check({tag, "_idle_busy"}, BUSY, 0);
        end
        START = 1'b0;
        LD_REQ = 1'b0;
        $display("sweep %s: words=%0d last_cyc=%0d done=%0d max_out=%0d", tag, hs, last_hs, done_cnt, max_out);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; W_READY = 1'b1;
        LD_REQ = 1'b0; LD_BANK = '0; LD_ADDR = '0; LD_DATA = '0;

        vecs[0] = '{1'b1, 5'd0,  5'd0,  16'h0011, 1'b1, 28'h0000001, 1'b1, 1'b1, 5'd0,  16'h0011};
        vecs[1] = '{1'b1, 5'd27, 5'd27, 16'hBEEF, 1'b1, 28'h8000000, 1'b1, 1'b1, 5'd27, 16'hBEEF};
        vecs[2] = '{1'b1, 5'd5,  5'd30, 16'h1111, 1'b1, 28'h0000000, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[3] = '{1'b1, 5'd28, 5'd3,  16'h2222, 1'b1, 28'h0000000, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[4] = '{1'b0, 5'd2,  5'd2,  16'h4444, 1'b0, 28'h0000000, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[5] = '{1'b1, 5'd14, 5'd13, 16'h5A5A, 1'b1, 28'h0004000, 1'b1, 1'b1, 5'd13, 16'h5A5A};
        vecs[6] = '{1'b1, 5'd31, 5'd31, 16'h3333, 1'b1, 28'h0000000, 1'b0, 1'b0, 5'd0,  16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_valid", W_VALID, 0);
        check("rst_last", W_LAST, 0);
        check("rst_en", BRAM_EN, 0);
        check("rst_we", BRAM_WE, 0);
        check("rst_ack", LD_ACK, 0);
        @(posedge clk); #1;
        RST = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            LD_REQ = vecs[v].req; LD_BANK = vecs[v].bank;
            LD_ADDR = vecs[v].addr; LD_DATA = vecs[v].data;
            @(negedge clk);
            check($sformatf("vec%0d_ack", v), LD_ACK, vecs[v].ack);
            check($sformatf("vec%0d_en", v), BRAM_EN, vecs[v].en);
            if (vecs[v].chk_wad) begin
                check($sformatf("vec%0d_we", v), BRAM_WE, vecs[v].we);
                check($sformatf("vec%0d_addr", v), BRAM_ADDR, vecs[v].eaddr);
                check($sformatf("vec%0d_di", v), BRAM_DI, vecs[v].edi);
            end
            $display("vec %0d: req=%0b bank=%0d addr=%0d ack=%0b en=%h", v, LD_REQ, LD_BANK, LD_ADDR, LD_ACK, BRAM_EN);
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                @(posedge clk); #1;
                LD_REQ = 1'b1; LD_BANK = BANK_W'(b); LD_ADDR = ADDR_W'(a);
                LD_DATA = DATA_W'(b * 32 + a);
                exp_mem[b][a] = DATA_W'(b * 32 + a);
                @(negedge clk);
                check("preload_ack", LD_ACK, 1);
            end
        end
        @(posedge clk); #1;
        LD_REQ = 1'b0;
        $display("preload: %0d words written", TOTAL_WEIGHTS);

        do_sweep("full",      0, 1'b0, 1'b0, -1);
        do_sweep("backpres",  1, 1'b0, 1'b0, -1);
        do_sweep("ld_mid",    0, 1'b1, 1'b0, -1);
        check("ld_mid_model", exp_mem[3][5], 16'h7A5A);
        do_sweep("start_ld",  0, 1'b0, 1'b1, -1);
        do_sweep("abort",     0, 1'b0, 1'b0, 400);
        do_sweep("stall",     2, 1'b0, 1'b0, -1);
        do_sweep("after",     0, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
